// File: rtl/ripple_counter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ripple_counter_pkg
//  Purpose  : Shared constants for the asynchronous ripple counter.
//  Revision : 1.0  initial release
// ============================================================================
package ripple_counter_pkg;

    localparam int RIPPLE_COUNTER_DEFAULT_WIDTH = 8;

endpackage : ripple_counter_pkg
`default_nettype wire

// File: rtl/ripple_counter_tff.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ripple_counter_tff
//  Purpose  : Toggle flip-flop with selectable trigger edge and async reset.
//  Revision : 1.0  initial release
// ============================================================================
module ripple_counter_tff #(
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic clk_in,
    input  logic reset,
    output logic q_out
);

    logic r_q;

    generate
        if (NEG_EDGE) begin : g_neg_edge
            // Inner stages toggle when the previous bit falls 1->0 (carry out).
            always_ff @(negedge clk_in or posedge reset) begin
                if (reset) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= ~r_q;
                end
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk_in or posedge reset) begin
                if (reset) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= ~r_q;
                end
            end
        end
    endgenerate

    assign q_out = r_q;

endmodule : ripple_counter_tff
`default_nettype wire

// File: rtl/ripple_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ripple_counter
//  Purpose  : Asynchronous binary up-counter built from a chain of TFFs.
//  Revision : 1.0  initial release
// ============================================================================
module ripple_counter
    import ripple_counter_pkg::*;
#(
    parameter int WIDTH = RIPPLE_COUNTER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_q;

    // Each stage is clocked by the bit below it, so q is not synchronous to clk.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_lsb
                ripple_counter_tff #(
                    .NEG_EDGE (1'b0)
                ) u_tff (
                    .clk_in (clk),
                    .reset  (reset),
                    .q_out  (w_q[i])
                );
            end else begin : g_carry
                ripple_counter_tff #(
                    .NEG_EDGE (1'b1)
                ) u_tff (
                    .clk_in (w_q[i-1]),
                    .reset  (reset),
                    .q_out  (w_q[i])
                );
            end
        end
    endgenerate

    assign q = w_q;

endmodule : ripple_counter
`default_nettype wire

// File: tb/tb_ripple_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ripple_counter
//  Purpose  : Scoreboard bench for the 8-bit ripple counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ripple_counter;

    localparam int C_WIDTH = 8;

    logic               clk;
    logic               reset;
    logic [C_WIDTH-1:0] q;

    logic [C_WIDTH-1:0] r_model;
    logic [C_WIDTH-1:0] sb_q[$];
    int                 n_vec;
    int                 n_err;

    ripple_counter #(
        .WIDTH (C_WIDTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [C_WIDTH-1:0] obs,
                         input logic [C_WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: q=%0d (0x%02h) expected %0d (0x%02h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic sample(input string tag);
        logic [C_WIDTH-1:0] exp;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, q=%0d", tag, q);
        end else begin
            exp = sb_q.pop_front();
            check(tag, q, exp);
        end
    endtask

    // One counted rising edge: predict, wait for the edge, compare after settle.
    task automatic step(input string tag);
        r_model = r_model + 1'b1;
        sb_q.push_back(r_model);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        r_model = '0;
        #1;
        sb_q.push_back('0);
        sample("reset_assert");
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        r_model = '0;

        // Reset held across 100 ns of clock activity.
        repeat (5) begin
            @(posedge clk);
            #1;
            sb_q.push_back('0);
            sample("rst_hold_pos");
            @(negedge clk);
            #1;
            sb_q.push_back('0);
            sample("rst_hold_neg");
        end

        @(negedge clk);
        reset = 1'b0;
        repeat (5) step("count");

        apply_reset();
        repeat (255) step("count_up");
        step("wrap");

        apply_reset();
        repeat (127) step("to_127");
        step("carry_128");
        check("carry_msb", {7'd0, q[7]}, 8'd1);
        check("carry_low", {1'b0, q[6:0]}, 8'd0);

        apply_reset();
        repeat (37) step("to_37");
        #4;
        sb_q.push_back(8'd37);
        sample("pre_mid_reset");
        reset = 1'b1;
        r_model = '0;
        #1;
        sb_q.push_back('0);
        sample("mid_reset");
        #1;
        reset = 1'b0;
        repeat (3) step("after_mid_reset");

        // Release coincident with a rising edge: scheduled so the edge still sees reset.
        @(negedge clk);
        reset = 1'b1;
        r_model = '0;
        #1;
        sb_q.push_back('0);
        sample("coinc_pre");
        @(posedge clk);
        reset <= 1'b0;
        #1;
        sb_q.push_back('0);
        sample("coinc_edge");
        step("coinc_next");

        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ripple_counter
`default_nettype wire
